wb_narrow_wide_bridge: RTL and testbench

//  Registered bridge from a narrow Wishbone classic master (MST_DW) to a wider slave (SLV_DW).

---
 rtl/wb_bridge_pkg.sv | 28 ++
 rtl/wb_timeout_ctr.sv | 39 +++
 rtl/wb_narrow_wide_bridge.sv | 191 +++++++++++++++++++
 tb/tb_wb_narrow_wide_bridge.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared types and helpers for the narrow-to-wide Wishbone bridge.
package wb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } bridge_state_t;

    typedef enum logic [1:0] {
        R_ACK = 2'd0,
        R_ERR = 2'd1,
        R_RTY = 2'd2
    } resp_t;

    // Widest lane count the select helper can express.
    localparam int MAX_LANES  = 16;
    localparam int LANE_IDX_W = 4;

    // One-hot byte-lane select for a lane index.
    function automatic logic [MAX_LANES-1:0] lane_sel(input logic [LANE_IDX_W-1:0] lane);
        logic [MAX_LANES-1:0] sel;
        sel       = '0;
        sel[lane] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Slave-wait watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the LIMIT-th enabled cycle is reached. LIMIT=0 disables it.
module wb_timeout_ctr #(
    parameter int          WIDTH = 8,
    parameter int unsigned LIMIT = 255
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [WIDTH-1:0] LAST = (LIMIT > 0) ? WIDTH'(LIMIT - 1) : '0;

    logic [WIDTH-1:0] cnt_q, cnt_d;

    // Next count: clear wins, otherwise advance while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (LIMIT != 0) && en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/wb_narrow_wide_bridge.sv
// Registered Wishbone classic bridge from a narrow master to a wide slave.
// Each narrow access becomes one wide slave cycle with a one-hot lane select
// and replicated write data; a one-word read buffer serves repeated reads.
module wb_narrow_wide_bridge
    import wb_bridge_pkg::*;
#(
    parameter int          ADR_W       = 32,
    parameter int          MST_DW      = 8,
    parameter int          SLV_DW      = 16,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter bit          READ_BUF    = 1'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       m_cyc_i,
    input  logic                       m_stb_i,
    input  logic                       m_we_i,
    input  logic [ADR_W-1:0]           m_adr_i,
    input  logic [MST_DW-1:0]          m_dat_i,
    output logic [MST_DW-1:0]          m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic                       m_rty_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [ADR_W-1:0]           s_adr_o,
    output logic [SLV_DW/MST_DW-1:0]   s_sel_o,
    output logic [SLV_DW-1:0]          s_dat_o,
    input  logic [SLV_DW-1:0]          s_dat_i,
    input  logic                       s_ack_i,
    input  logic                       s_err_i,
    input  logic                       s_rty_i,
    input  logic                       inv_i
);

    localparam int LANES  = SLV_DW / MST_DW;
    localparam int LSB    = $clog2(LANES);
    localparam int WORD_W = ADR_W - LSB;
    localparam int TO_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    // A bridge between equal widths makes no sense, and the lane helper is bounded.
    if ((SLV_DW % MST_DW) != 0 || LANES < 2 || (LANES & (LANES - 1)) != 0 || LANES > MAX_LANES) begin : g_bad_cfg
        $error("wb_narrow_wide_bridge: SLV_DW must be MST_DW times a power of two between 2 and 16");
    end

    bridge_state_t     state_q, state_d;
    resp_t             resp_q, resp_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [LSB-1:0]    lane_q, lane_d;
    logic              we_q, we_d;
    logic [MST_DW-1:0] dat_q, dat_d;
    logic [MST_DW-1:0] m_dat_q, m_dat_d;
    logic [SLV_DW-1:0] buf_dat_q, buf_dat_d;
    logic [WORD_W-1:0] buf_tag_q, buf_tag_d;
    logic              buf_vld_q, buf_vld_d;

    logic              buf_kill;
    logic              to_clr;
    logic              to_expired;
    logic              in_bus;
    logic              rd_hit;
    logic [LSB-1:0]    m_lane;
    logic [WORD_W-1:0] m_word;

    assign m_lane = m_adr_i[LSB-1:0];
    assign m_word = m_adr_i[ADR_W-1:LSB];
    assign in_bus = (state_q == BUS);

    // An invalidate in the lookup cycle forces a miss so stale data is never returned.
    assign rd_hit = READ_BUF && !m_we_i && buf_vld_q && (buf_tag_q == m_word) && !inv_i;

    wb_timeout_ctr #(
        .WIDTH (TO_W),
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr     (to_clr),
        .en      (in_bus),
        .expired (to_expired)
    );

    // Next-state, captured request, response and read-buffer maintenance.
    always_comb begin
        state_d   = state_q;
        resp_d    = resp_q;
        word_d    = word_q;
        lane_d    = lane_q;
        we_d      = we_q;
        dat_d     = dat_q;
        m_dat_d   = m_dat_q;
        buf_dat_d = buf_dat_q;
        buf_tag_d = buf_tag_q;
        buf_vld_d = buf_vld_q;
        buf_kill  = 1'b0;
        to_clr    = 1'b0;
        case (state_q)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    if (rd_hit) begin
                        state_d = RESP;
                        resp_d  = R_ACK;
                        m_dat_d = buf_dat_q[m_lane*MST_DW +: MST_DW];
                    end else begin
                        state_d = BUS;
                        word_d  = m_word;
                        lane_d  = m_lane;
                        we_d    = m_we_i;
                        dat_d   = m_dat_i;
                        to_clr  = 1'b1;
                    end
                end
            end
            BUS: begin
                if (!m_cyc_i) begin
                    // Master abandoned the cycle: release the slave silently.
                    state_d = IDLE;
                end else if (s_err_i || s_rty_i) begin
                    state_d  = RESP;
                    resp_d   = s_err_i ? R_ERR : R_RTY;
                    buf_kill = (buf_tag_q == word_q);
                end else if (s_ack_i) begin
                    state_d = RESP;
                    resp_d  = R_ACK;
                    if (!we_q) begin
                        m_dat_d   = s_dat_i[lane_q*MST_DW +: MST_DW];
                        buf_dat_d = s_dat_i;
                        buf_tag_d = word_q;
                        buf_vld_d = READ_BUF;
                    end else if (buf_vld_q && (buf_tag_q == word_q)) begin
                        buf_dat_d[lane_q*MST_DW +: MST_DW] = dat_q;
                    end
                end else if (to_expired) begin
                    state_d  = RESP;
                    resp_d   = R_ERR;
                    buf_kill = (buf_tag_q == word_q);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (inv_i || buf_kill) begin
            buf_vld_d = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            resp_q    <= R_ACK;
            word_q    <= '0;
            lane_q    <= '0;
            we_q      <= 1'b0;
            dat_q     <= '0;
            m_dat_q   <= '0;
            buf_dat_q <= '0;
            buf_tag_q <= '0;
            buf_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            resp_q    <= resp_d;
            word_q    <= word_d;
            lane_q    <= lane_d;
            we_q      <= we_d;
            dat_q     <= dat_d;
            m_dat_q   <= m_dat_d;
            buf_dat_q <= buf_dat_d;
            buf_tag_q <= buf_tag_d;
            buf_vld_q <= buf_vld_d;
        end
    end

    assign s_cyc_o = in_bus;
    assign s_stb_o = in_bus;
    assign s_we_o  = in_bus && we_q;
    assign s_adr_o = in_bus ? {word_q, {LSB{1'b0}}} : '0;
    assign s_sel_o = in_bus ? LANES'(lane_sel(LANE_IDX_W'(lane_q))) : '0;
    assign s_dat_o = in_bus ? {LANES{dat_q}} : '0;

    assign m_ack_o = (state_q == RESP) && (resp_q == R_ACK);
    assign m_err_o = (state_q == RESP) && (resp_q == R_ERR);
    assign m_rty_o = (state_q == RESP) && (resp_q == R_RTY);
    assign m_dat_o = m_dat_q;

endmodule

// File: tb/tb_wb_narrow_wide_bridge.sv
// Directed bench for wb_narrow_wide_bridge: a 16-bit instance with a short
// timeout and a 32-bit instance, driven from one master/slave stimulus set.
module tb_wb_narrow_wide_bridge;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        m_cyc = 1'b0, m_stb = 1'b0, m_we = 1'b0, sel_b = 1'b0, inv = 1'b0;
    logic [31:0] m_adr = '0;
    logic [7:0]  m_dat = '0;
    logic [31:0] s_rdat = '0;
    logic        s_ack = 1'b0, s_err = 1'b0, s_rty = 1'b0;

    logic [7:0]  a_mdat, b_mdat;
    logic        a_ack, a_err, a_rty, a_cyc, a_stb, a_we;
    logic        b_ack, b_err, b_rty, b_cyc, b_stb, b_we;
    logic [31:0] a_adr, b_adr;
    logic [1:0]  a_sel;
    logic [3:0]  b_sel;
    logic [15:0] a_sdat;
    logic [31:0] b_sdat;

    wb_narrow_wide_bridge #(.ADR_W(32), .MST_DW(8), .SLV_DW(16), .TIMEOUT_CYC(4), .READ_BUF(1'b1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_cyc_i(m_cyc & ~sel_b), .m_stb_i(m_stb & ~sel_b), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_dat_o(a_mdat), .m_ack_o(a_ack), .m_err_o(a_err), .m_rty_o(a_rty),
        .s_cyc_o(a_cyc), .s_stb_o(a_stb), .s_we_o(a_we), .s_adr_o(a_adr), .s_sel_o(a_sel), .s_dat_o(a_sdat),
        .s_dat_i(s_rdat[15:0]), .s_ack_i(s_ack & ~sel_b), .s_err_i(s_err & ~sel_b), .s_rty_i(s_rty & ~sel_b),
        .inv_i(inv)
    );

    wb_narrow_wide_bridge #(.ADR_W(32), .MST_DW(8), .SLV_DW(32), .TIMEOUT_CYC(255), .READ_BUF(1'b1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_cyc_i(m_cyc & sel_b), .m_stb_i(m_stb & sel_b), .m_we_i(m_we), .m_adr_i(m_adr), .m_dat_i(m_dat),
        .m_dat_o(b_mdat), .m_ack_o(b_ack), .m_err_o(b_err), .m_rty_o(b_rty),
        .s_cyc_o(b_cyc), .s_stb_o(b_stb), .s_we_o(b_we), .s_adr_o(b_adr), .s_sel_o(b_sel), .s_dat_o(b_sdat),
        .s_dat_i(s_rdat), .s_ack_i(s_ack & sel_b), .s_err_i(s_err & sel_b), .s_rty_i(s_rty & sel_b),
        .inv_i(inv)
    );

    // Observed view of whichever instance is selected.
    logic [7:0]  o_mdat;
    logic        o_ack, o_err, o_rty, o_cyc, o_stb, o_we;
    logic [31:0] o_adr, o_sdat;
    logic [3:0]  o_sel;
    assign o_mdat = sel_b ? b_mdat : a_mdat;
    assign o_ack  = sel_b ? b_ack  : a_ack;
    assign o_err  = sel_b ? b_err  : a_err;
    assign o_rty  = sel_b ? b_rty  : a_rty;
    assign o_cyc  = sel_b ? b_cyc  : a_cyc;
    assign o_stb  = sel_b ? b_stb  : a_stb;
    assign o_we   = sel_b ? b_we   : a_we;
    assign o_adr  = sel_b ? b_adr  : a_adr;
    assign o_sel  = sel_b ? b_sel  : {2'b00, a_sel};
    assign o_sdat = sel_b ? b_sdat : {16'h0000, a_sdat};

    typedef struct {
        int         kind;   // 0 ack, 1 err, 2 rty
        logic [7:0] data;
        bit         is_rd;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One master access with a scripted slave. sresp: 0 ack, 1 err, 2 rty, 3 silent, 4 ack+err.
    task automatic xact(input string tag, input bit use_b, input bit we, input logic [31:0] adr,
                        input logic [7:0] wd, input int sresp, input int wait_cyc, input logic [31:0] srd,
                        input bit exp_slv, input logic [31:0] exp_sadr, input logic [3:0] exp_sel,
                        input logic [31:0] exp_sdat, input int exp_kind, input logic [7:0] exp_dat,
                        input int exp_lat, input bit inv_in_resp);
        exp_t e;
        int   n, w, scyc;
        bit   seen, done;
        sb.push_back('{kind: exp_kind, data: exp_dat, is_rd: !we});
        sel_b  = use_b;
        m_cyc  = 1'b1; m_stb = 1'b1; m_we = we; m_adr = adr; m_dat = wd; s_rdat = srd;
        n = 0; w = 0; scyc = 0; seen = 1'b0; done = 1'b0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
            if (o_ack || o_err || o_rty) begin
                done = 1'b1;
            end else if (o_cyc) begin
                scyc++;
                if (!seen) begin
                    seen = 1'b1;
                    chk({tag, ".s_adr"}, o_adr, exp_sadr);
                    chk({tag, ".s_sel"}, o_sel, exp_sel);
                    chk({tag, ".s_dat"}, o_sdat, exp_sdat);
                    chk({tag, ".s_we_stb"}, {o_we, o_stb}, {we, 1'b1});
                end
                if (w == wait_cyc) begin
                    case (sresp)
                        0: s_ack = 1'b1;
                        1: s_err = 1'b1;
                        2: s_rty = 1'b1;
                        4: begin s_ack = 1'b1; s_err = 1'b1; end
                        default: ;
                    endcase
                end
                w++;
            end
        end
        e = sb.pop_front();
        $display("xact %s: adr=%h we=%0d lat=%0d slave=%0d resp=%b rdata=%h", tag, adr, we, n, seen,
                 {o_ack, o_err, o_rty}, o_mdat);
        chk({tag, ".latency"}, n, exp_lat);
        chk({tag, ".slave_used"}, seen, exp_slv);
        chk({tag, ".resp"}, {o_ack, o_err, o_rty}, (e.kind == 0) ? 3'b100 : (e.kind == 1) ? 3'b010 : 3'b001);
        if (e.is_rd && e.kind == 0) chk({tag, ".rdata"}, o_mdat, e.data);
        if (sresp == 3) chk({tag, ".s_cyc_cycles"}, scyc, 4);
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        if (inv_in_resp) inv = 1'b1;
        @(negedge clk);
        inv = 1'b0;
        chk({tag, ".one_pulse"}, {o_ack, o_err, o_rty, o_cyc}, 4'b0000);
        if (e.is_rd && e.kind == 0) chk({tag, ".hold"}, o_mdat, e.data);
    endtask

    // Hard bound on the whole run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst.m_resp", {a_ack, a_err, a_rty, b_ack, b_err, b_rty}, 6'b0);
        chk("rst.slave", {a_cyc, a_stb, a_we, a_adr, a_sel, a_sdat}, '0);
        chk("rst.m_dat", {a_mdat, b_mdat}, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.idle", {a_cyc, b_cyc, a_ack, b_ack}, 4'b0000);

        // Miss with wait states, then hit on the other lane.
        xact("t1.rd_miss", 0, 0, 32'h1001, 8'h00, 0, 2, 32'hBEEF, 1, 32'h1000, 4'b0010, 32'h0, 0, 8'hBE, 4, 0);
        xact("t2.rd_hit", 0, 0, 32'h1000, 8'h00, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0, 8'hEF, 1, 0);
        // Write updates only its lane of the buffered word.
        xact("t3.wr", 0, 1, 32'h1000, 8'h55, 0, 0, 32'h0, 1, 32'h1000, 4'b0001, 32'h5555, 0, 8'h00, 2, 0);
        xact("t3.hit0", 0, 0, 32'h1000, 8'h00, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0, 8'h55, 1, 0);
        xact("t3.hit1", 0, 0, 32'h1001, 8'h00, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0, 8'hBE, 1, 0);
        // Timeout on another word leaves the buffer intact.
        xact("t4.timeout", 0, 0, 32'h4000, 8'h00, 3, 0, 32'h0, 1, 32'h4000, 4'b0001, 32'h0, 1, 8'h00, 5, 0);
        xact("t4.keep", 0, 0, 32'h1001, 8'h00, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0, 8'hBE, 1, 0);
        // Error to the buffered word invalidates; retry; ack+err gives err only; refill.
        xact("t5.wr_err", 0, 1, 32'h1001, 8'h77, 1, 1, 32'h0, 1, 32'h1000, 4'b0010, 32'h7777, 1, 8'h00, 3, 0);
        xact("t5.rty", 0, 0, 32'h1000, 8'h00, 2, 0, 32'h0, 1, 32'h1000, 4'b0001, 32'h0, 2, 8'h00, 2, 0);
        xact("t5.ack_err", 0, 0, 32'h1000, 8'h00, 4, 0, 32'h9999, 1, 32'h1000, 4'b0001, 32'h0, 1, 8'h00, 2, 0);
        xact("t5.fill", 0, 0, 32'h1000, 8'h00, 0, 0, 32'hA1B2, 1, 32'h1000, 4'b0001, 32'h0, 0, 8'hB2, 2, 0);

        // Abort: master drops cyc in BUS while the slave acks in the same cycle.
        sel_b = 1'b0; m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h3000; s_rdat = 32'h1234;
        @(negedge clk);
        chk("abort.in_bus", o_cyc, 1'b1);
        m_cyc = 1'b0; m_stb = 1'b0; s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        $display("xact abort: adr=00003000 s_cyc=%0d resp=%b", o_cyc, {o_ack, o_err, o_rty});
        chk("abort.release", {o_cyc, o_stb, o_ack, o_err, o_rty}, 5'b0);
        @(negedge clk);
        chk("abort.quiet", {o_cyc, o_ack, o_err, o_rty}, 4'b0);
        xact("abort.buf_kept", 0, 0, 32'h1001, 8'h00, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0, 8'hA1, 1, 0);

        // Reset in the middle of a slave cycle: immediate release, no late response.
        m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h5000;
        @(negedge clk);
        chk("rst_mid.in_bus", o_cyc, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid.async", {o_cyc, o_stb}, 2'b00);
        @(negedge clk);
        m_cyc = 1'b0; m_stb = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rst_mid.no_resp", {o_ack, o_err, o_rty, o_cyc}, 4'b0);
        end
        $display("xact rst_mid: adr=00005000 cleared");
        // Buffer was cleared by reset, so this must miss.
        xact("t7.post_rst", 0, 0, 32'h1001, 8'h00, 0, 0, 32'hC3D4, 1, 32'h1000, 4'b0010, 32'h0, 0, 8'hC3, 2, 0);

        // 32-bit slave: top lane, invalidate during RESP, re-read misses.
        xact("t6.rd1", 1, 0, 32'h2003, 8'h00, 0, 0, 32'hDEADBEEF, 1, 32'h2000, 4'b1000, 32'h0, 0, 8'hDE, 2, 1);
        xact("t6.rd2", 1, 0, 32'h2003, 8'h00, 0, 1, 32'h11223344, 1, 32'h2000, 4'b1000, 32'h0, 0, 8'h11, 3, 0);
        xact("t6.hit", 1, 0, 32'h2000, 8'h00, 0, 0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 0, 8'h44, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
